lsu_axil: RTL and testbench

//  Load/store unit between the execute stage and the writeback stage: one memory op per request.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_axil_if.sv | 38 +++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu_axil.sv | 212 +++++++++++++++++++++
 tb/tb_lsu_axil.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the AXI4-Lite load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDATA,
        WR,
        WRESP,
        ERR_RSP,
        RSP
    } lsu_state_t;

    localparam logic [2:0] MR_LB  = 3'd0;
    localparam logic [2:0] MR_LH  = 3'd1;
    localparam logic [2:0] MR_LW  = 3'd2;
    localparam logic [2:0] MR_LBU = 3'd4;
    localparam logic [2:0] MR_LHU = 3'd5;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic mr_legal(input logic [2:0] mr);
        case (mr)
            MR_LB, MR_LH, MR_LW, MR_LBU, MR_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_axil_if.sv
// AXI4-Lite bus bundle; master modport is the LSU, slave modport is the memory side.
interface lsu_axil_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store lane placement, load extraction/extension,
// and legality/alignment check of an incoming op.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  chk_addr_lo_i,
    input  logic [2:0]  chk_mrtype_i,
    output logic        misaligned_o,
    output logic        illegal_o,

    input  logic [1:0]  offset_i,
    input  logic [2:0]  mrtype_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] ldata_o
);

    logic [3:0]  strb_base;
    logic [31:0] ld_shifted;

    assign illegal_o = !mr_legal(chk_mrtype_i);

    always_comb begin
        misaligned_o = 1'b0;
        case (chk_mrtype_i[1:0])
            2'd1:    misaligned_o = chk_addr_lo_i[0];
            2'd2:    misaligned_o = |chk_addr_lo_i;
            default: misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        strb_base = 4'b1111;
        case (mrtype_i[1:0])
            2'd0:    strb_base = 4'b0001;
            2'd1:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
    end

    assign wdata_o    = wdata_i << {offset_i, 3'b000};
    assign wstrb_o    = strb_base << offset_i;
    assign ld_shifted = rdata_i >> {offset_i, 3'b000};

    // mrtype[2] selects zero extension (LBU/LHU)
    always_comb begin
        ldata_o = ld_shifted;
        case (mrtype_i[1:0])
            2'd0: ldata_o = mrtype_i[2] ? {24'b0, ld_shifted[7:0]}
                                        : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            2'd1: ldata_o = mrtype_i[2] ? {16'b0, ld_shifted[15:0]}
                                        : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            default: ldata_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_axil.sv
// Load/store unit: one op at a time, executed as a single AXI4-Lite transaction,
// result held in one response register until writeback takes it.
module lsu_axil
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wen_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [2:0]            req_mrtype_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,

    lsu_axil_if.master            axi
);

    lsu_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            mrtype_q, mrtype_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;

    logic                  misaligned;
    logic                  illegal;
    logic [31:0]           bus_wdata;
    logic [3:0]            bus_wstrb;
    logic [31:0]           ld_data;
    logic                  aw_fin;
    logic                  w_fin;

    // Check path looks at the live request; data path at the latched one.
    lsu_align u_align (
        .chk_addr_lo_i (req_addr_i[1:0]),
        .chk_mrtype_i  (req_mrtype_i),
        .misaligned_o  (misaligned),
        .illegal_o     (illegal),
        .offset_i      (addr_q[1:0]),
        .mrtype_i      (mrtype_q),
        .wdata_i       (wdata_q),
        .rdata_i       (axi.rdata),
        .wdata_o       (bus_wdata),
        .wstrb_o       (bus_wstrb),
        .ldata_o       (ld_data)
    );

    assign aw_fin = aw_done_q || (awvalid_q && axi.awready);
    assign w_fin  = w_done_q  || (wvalid_q  && axi.wready);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mrtype_d    = mrtype_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    mrtype_d = req_mrtype_i;
                    if (illegal || (misaligned && MISALIGN_TRAP)) begin
                        state_d = ERR_RSP;
                    end else begin
                        // Untrapped misaligned ops are forced onto lane 0
                        if (misaligned) addr_d[1:0] = 2'b00;
                        if (req_wen_i) begin
                            state_d   = WR;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            aw_done_d = 1'b0;
                            w_done_d  = 1'b0;
                        end else begin
                            state_d   = RD;
                            arvalid_d = 1'b1;
                        end
                    end
                end
            end
            RD: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (axi.rvalid) begin
                    rready_d    = 1'b0;
                    rsp_err_d   = (axi.rresp != AXI_RESP_OKAY);
                    rsp_rdata_d = (axi.rresp != AXI_RESP_OKAY) ? 32'd0 : ld_data;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            WR: begin
                if (awvalid_q && axi.awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && axi.wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (axi.bvalid) begin
                    bready_d    = 1'b0;
                    rsp_err_d   = (axi.bresp != AXI_RESP_OKAY);
                    rsp_rdata_d = 32'd0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            ERR_RSP: begin
                rsp_err_d   = 1'b1;
                rsp_rdata_d = 32'd0;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            mrtype_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mrtype_q    <= mrtype_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

    assign axi.araddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = bus_wdata;
    assign axi.wstrb   = bus_wstrb;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_lsu_axil.sv
// Directed scoreboard bench for lsu_axil: stimulus pushes expected responses,
// a monitor pops them on each response handshake; AXI slave models check bus payloads.
module tb_lsu_axil;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_mrtype;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    lsu_axil_if #(.ADDR_WIDTH(32)) axi ();

    lsu_axil #(.ADDR_WIDTH(32), .MISALIGN_TRAP(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_wen_i    (req_wen),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_mrtype_i (req_mrtype),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .axi          (axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cyc = 0;
    int          ar_cnt = 0;
    int          aw_cnt = 0;
    logic [31:0] exp_addr, exp_wdata, sl_rdata;
    logic [3:0]  exp_wstrb;
    logic [1:0]  sl_rresp, sl_bresp;
    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0;
    bit          abort_rd = 1'b0, aw_hs = 1'b0, w_hs = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor / scoreboard
    initial begin : monitor
        exp_t        e;
        bit          seen = 1'b0;
        int          first = 0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_rd = '0;
        logic        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (prev_stall) begin
                chk("rsp_hold_ctl", {29'd0, rsp_valid, req_ready, rsp_err}, {29'd0, 1'b1, 1'b0, prev_err});
                chk("rsp_hold_data", rsp_rdata, prev_rd);
            end
            if (rsp_valid && !seen) begin
                seen  = 1'b1;
                first = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                $display("rsp rdata=%h err=%0d cycle=%0d", rsp_rdata, rsp_err, cyc);
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    if (e.lat >= 0) chk("rsp_latency", first - e.acc, e.lat);
                end
                seen = 1'b0;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_rd    = rsp_rdata;
            prev_err   = rsp_err;
        end
    end

    // Read slave
    initial begin : rd_slave
        int n;
        forever begin
            @(negedge clk);
            if (axi.arvalid) begin
                ar_cnt++;
                chk("araddr", axi.araddr, exp_addr);
                repeat (ar_wait) @(negedge clk);
                axi.arready = 1'b1;
                @(negedge clk);
                axi.arready = 1'b0;
                chk("arvalid_drop", {31'd0, axi.arvalid}, 32'd0);
                repeat (r_wait) @(negedge clk);
                axi.rdata  = sl_rdata;
                axi.rresp  = sl_rresp;
                axi.rvalid = 1'b1;
                n = 0;
                while (!axi.rready && !abort_rd && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (!abort_rd) begin
                    chk("rready_seen", {31'd0, n < 100}, 32'd1);
                    @(negedge clk);
                end
                axi.rvalid = 1'b0;
            end
        end
    end

    // Write address slave
    initial forever begin
        @(negedge clk);
        if (axi.awvalid) begin
            aw_cnt++;
            chk("awaddr", axi.awaddr, exp_addr);
            repeat (aw_wait) @(negedge clk);
            axi.awready = 1'b1;
            @(negedge clk);
            axi.awready = 1'b0;
            aw_hs = 1'b1;
            chk("awvalid_drop", {31'd0, axi.awvalid}, 32'd0);
        end
    end

    // Write data slave
    initial forever begin
        @(negedge clk);
        if (axi.wvalid) begin
            chk("wdata", axi.wdata, exp_wdata);
            chk("wstrb", {28'd0, axi.wstrb}, {28'd0, exp_wstrb});
            repeat (w_wait) @(negedge clk);
            chk("wvalid_hold", {31'd0, axi.wvalid}, 32'd1);
            axi.wready = 1'b1;
            @(negedge clk);
            axi.wready = 1'b0;
            w_hs = 1'b1;
        end
    end

    // Write response slave; samples late so both handshake flags have settled
    initial forever begin
        @(negedge clk);
        #2;
        if (axi.bready) begin
            chk("bready_after_both", {30'd0, aw_hs, w_hs}, 32'd3);
            aw_hs      = 1'b0;
            w_hs       = 1'b0;
            axi.bresp  = sl_bresp;
            axi.bvalid = 1'b1;
            @(negedge clk);
            axi.bvalid = 1'b0;
        end
    end

    task automatic do_op(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] mr, input logic [31:0] erd, input bit eerr,
                         input int elat, input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wd;
        req_mrtype = mr;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", {31'd0, n < 200}, 32'd1);
        if (push) begin
            e.rdata = erd;
            e.err   = eerr;
            e.lat   = elat;
            e.acc   = cyc;
            sb_q.push_back(e);
        end
        $display("op wen=%0d addr=%h wdata=%h mrtype=%0d cycle=%0d", wen, addr, wd, mr, cyc);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || !req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'd0, n < 300}, 32'd1);
    endtask

    task automatic rd_cfg(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        exp_addr = a;
        sl_rdata = d;
        sl_rresp = resp;
    endtask

    task automatic wr_cfg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp);
        exp_addr  = a;
        exp_wdata = d;
        exp_wstrb = s;
        sl_bresp  = resp;
    endtask

    initial begin : stim
        int snap_ar, snap_aw, n;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_mrtype = '0;
        rsp_ready = 1'b1;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
        exp_addr = '0; exp_wdata = '0; exp_wstrb = '0; sl_rdata = '0;
        sl_rresp = '0; sl_bresp = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {24'd0, req_ready, rsp_valid, rsp_err, axi.arvalid, axi.rready,
                          axi.awvalid, axi.wvalid, axi.bready}, 32'h80);
        chk("reset_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;

        // Loads, zero-wait slave
        rd_cfg(32'h8000_0004, 32'hDEAD_BEEF, 2'b00);
        do_op(1'b0, 32'h8000_0004, 32'd0, MR_LW, 32'hDEAD_BEEF, 1'b0, 3, 1'b1);
        wait_idle();
        rd_cfg(32'h8000_0000, 32'h80FF_0000, 2'b00);
        do_op(1'b0, 32'h8000_0003, 32'd0, MR_LB, 32'hFFFF_FF80, 1'b0, 3, 1'b1);
        wait_idle();
        do_op(1'b0, 32'h8000_0003, 32'd0, MR_LBU, 32'h0000_0080, 1'b0, 3, 1'b1);
        wait_idle();
        do_op(1'b0, 32'h8000_0002, 32'd0, MR_LHU, 32'h0000_80FF, 1'b0, 3, 1'b1);
        wait_idle();
        do_op(1'b0, 32'h8000_0002, 32'd0, MR_LH, 32'hFFFF_80FF, 1'b0, 3, 1'b1);
        wait_idle();

        // Stores
        wr_cfg(32'h8000_0000, 32'hABCD_0000, 4'b1100, 2'b00);
        do_op(1'b1, 32'h8000_0002, 32'h1234_ABCD, MR_LH, 32'd0, 1'b0, 3, 1'b1);
        wait_idle();
        wr_cfg(32'h8000_0000, 32'h0000_A500, 4'b0010, 2'b00);
        do_op(1'b1, 32'h8000_0001, 32'h0000_00A5, MR_LB, 32'd0, 1'b0, 3, 1'b1);
        wait_idle();
        // AW accepted 3 cycles ahead of W, slave error on B
        aw_wait = 0;
        w_wait  = 3;
        wr_cfg(32'h8000_0008, 32'h1122_3344, 4'b1111, 2'b10);
        do_op(1'b1, 32'h8000_0008, 32'h1122_3344, MR_LW, 32'd0, 1'b1, -1, 1'b1);
        wait_idle();
        w_wait = 0;

        // Trapped ops: misaligned word, illegal mrtype load and store
        snap_ar = ar_cnt;
        snap_aw = aw_cnt;
        do_op(1'b0, 32'h8000_0001, 32'd0, MR_LW, 32'd0, 1'b1, 2, 1'b1);
        wait_idle();
        do_op(1'b0, 32'h8000_0000, 32'd0, 3'd3, 32'd0, 1'b1, 2, 1'b1);
        wait_idle();
        do_op(1'b1, 32'h8000_0000, 32'h5555_5555, 3'd7, 32'd0, 1'b1, 2, 1'b1);
        wait_idle();
        chk("no_arvalid", ar_cnt, snap_ar);
        chk("no_awvalid", aw_cnt, snap_aw);

        // Read error response
        rd_cfg(32'h8000_0010, 32'h1234_5678, 2'b10);
        do_op(1'b0, 32'h8000_0010, 32'd0, MR_LW, 32'd0, 1'b1, 3, 1'b1);
        wait_idle();

        // Writeback stall for 5 cycles
        rd_cfg(32'h8000_000C, 32'h0BAD_F00D, 2'b00);
        rsp_ready = 1'b0;
        do_op(1'b0, 32'h8000_000C, 32'd0, MR_LW, 32'h0BAD_F00D, 1'b0, -1, 1'b1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        repeat (5) @(negedge clk);
        rsp_ready = 1'b1;
        wait_idle();

        // Reset while waiting for read data
        rd_cfg(32'h8000_0020, 32'h0000_0055, 2'b00);
        r_wait = 6;
        do_op(1'b0, 32'h8000_0020, 32'd0, MR_LW, 32'd0, 1'b0, -1, 1'b0);
        n = 0;
        while (!axi.rready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rdata_reached", {31'd0, axi.rready}, 32'd1);
        abort_rd = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_reset_ctl", {24'd0, req_ready, rsp_valid, rsp_err, axi.arvalid, axi.rready,
                              axi.awvalid, axi.wvalid, axi.bready}, 32'h80);
        chk("mid_reset_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        abort_rd = 1'b0;
        r_wait   = 0;

        // Recovery after reset
        rd_cfg(32'h8000_0024, 32'hCAFE_1234, 2'b00);
        do_op(1'b0, 32'h8000_0026, 32'd0, MR_LHU, 32'h0000_CAFE, 1'b0, 3, 1'b1);
        wait_idle();

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
